// File: rtl/td4_prog_loader.sv
// rtl/td4_prog_loader.sv - serial loader and combinational read port for the 16x8 TD4 program memory
// Optional checksum byte after the program: define TD4_LOADER_CHECKSUM_EN.
module td4_prog_loader #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              sdi,
    input  logic              sdi_valid,
    input  logic [ADDR_W-1:0] rom_addr,
    output logic [DATA_W-1:0] rom_data,
    output logic              cpu_rst_n,
    output logic              busy,
    output logic              done,
    output logic              err
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

`ifdef TD4_LOADER_CHECKSUM_EN
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CHECK, S_DONE} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;
`endif

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    // Only the seven previously received bits need storing; the eighth arrives on sdi.
    logic [DATA_W-2:0]   shreg_q, shreg_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic [DATA_W-1:0]   mem_d [DEPTH];
    logic [DATA_W-1:0]   byte_in;
`ifdef TD4_LOADER_CHECKSUM_EN
    logic [DATA_W-1:0]   sum_q, sum_d;
    logic                err_q, err_d;
`endif

    assign byte_in = {shreg_q, sdi};

    always_comb begin
        state_d   = state_q;
        waddr_d   = waddr_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        mem_d     = mem_q;
`ifdef TD4_LOADER_CHECKSUM_EN
        sum_d     = sum_q;
        err_d     = err_q;
`endif
        if (start) begin
            state_d   = S_LOAD;
            waddr_d   = '0;
            bit_cnt_d = '0;
`ifdef TD4_LOADER_CHECKSUM_EN
            sum_d     = '0;
            err_d     = 1'b0;
`endif
        end else begin
            case (state_q)
                S_LOAD: begin
                    if (sdi_valid) begin
                        shreg_d   = byte_in[DATA_W-2:0];
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        if (bit_cnt_q == LAST_BIT) begin
                            bit_cnt_d      = '0;
                            mem_d[waddr_q] = byte_in;
                            waddr_d        = waddr_q + 1'b1;
`ifdef TD4_LOADER_CHECKSUM_EN
                            sum_d          = sum_q + byte_in;
                            if (waddr_q == '1) state_d = S_CHECK;
`else
                            if (waddr_q == '1) state_d = S_DONE;
`endif
                        end
                    end
                end
`ifdef TD4_LOADER_CHECKSUM_EN
                S_CHECK: begin
                    // The trailing checksum byte is compared, never written to memory.
                    if (sdi_valid) begin
                        shreg_d   = byte_in[DATA_W-2:0];
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        if (bit_cnt_q == LAST_BIT) begin
                            bit_cnt_d = '0;
                            if (byte_in == sum_q) begin
                                err_d   = 1'b0;
                                state_d = S_DONE;
                            end else begin
                                err_d   = 1'b1;
                                state_d = S_IDLE;
                            end
                        end
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            waddr_q   <= '0;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            mem_q     <= '{default: '0};
`ifdef TD4_LOADER_CHECKSUM_EN
            sum_q     <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            waddr_q   <= waddr_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            mem_q     <= mem_d;
`ifdef TD4_LOADER_CHECKSUM_EN
            sum_q     <= sum_d;
            err_q     <= err_d;
`endif
        end
    end

    assign rom_data  = mem_q[rom_addr];
    assign done      = (state_q == S_DONE);
    assign cpu_rst_n = (state_q == S_DONE);
`ifdef TD4_LOADER_CHECKSUM_EN
    assign busy      = (state_q == S_LOAD) || (state_q == S_CHECK);
    assign err       = err_q;
`else
    assign busy      = (state_q == S_LOAD);
    assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_td4_prog_loader.sv
// tb/tb_td4_prog_loader.sv - table-driven, scoreboarded bench for td4_prog_loader
module tb_td4_prog_loader;
    logic       clk = 1'b0;
    logic       rst, start, sdi, sdi_valid;
    logic [3:0] rom_addr;
    logic [7:0] rom_data;
    logic       cpu_rst_n, busy, done, err;

    td4_prog_loader #(.ADDR_W(4), .DATA_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .sdi(sdi), .sdi_valid(sdi_valid),
        .rom_addr(rom_addr), .rom_data(rom_data), .cpu_rst_n(cpu_rst_n),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] addr;
        logic [7:0] data;
    } rom_vec_t;

    rom_vec_t   vec [16];
    rom_vec_t   sb [$];
    logic [7:0] prog_cur [16];
    int         checks = 0;
    int         errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input bit gapped);
        if (gapped) begin
            for (int g = 0; g < 4 && $urandom_range(1) == 0; g++) begin
                sdi_valid = 1'b0;
                sdi       = 1'($urandom_range(1));
                tick();
                check("busy_in_gap", busy, 1);
            end
        end
        sdi       = b;
        sdi_valid = 1'b1;
        tick();
        sdi_valid = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gapped);
        for (int k = 7; k >= 0; k--) send_bit(b[k], gapped);
    endtask

    // Final byte of a load: done must stay low until its last bit edge, then rise at once.
    task automatic send_last(input logic [7:0] b, input bit gapped);
        for (int k = 7; k >= 1; k--) send_bit(b[k], gapped);
        check("done_before_last_edge", done, 0);
        check("busy_before_last_edge", busy, 1);
        send_bit(b[0], gapped);
        check("done_after_last_edge", done, 1);
        check("cpu_rst_n_after_load", cpu_rst_n, 1);
        check("busy_after_load", busy, 0);
        check("err_after_load", err, 0);
    endtask

    task automatic pulse_start();
        start     = 1'b1;
        sdi_valid = 1'b1;
        sdi       = 1'b1;
        tick();
        start     = 1'b0;
        sdi_valid = 1'b0;
    endtask

    task automatic load_program(input bit gapped);
        logic [7:0] s;
        s = 8'h00;
        pulse_start();
        check("busy_after_start", busy, 1);
        for (int i = 0; i < 16; i++) begin
            sb.push_back('{addr: 4'(i), data: prog_cur[i]});
            s = s + prog_cur[i];
`ifdef TD4_LOADER_CHECKSUM_EN
            send_byte(prog_cur[i], gapped);
`else
            if (i < 15) send_byte(prog_cur[i], gapped);
            else        send_last(prog_cur[i], gapped);
`endif
        end
`ifdef TD4_LOADER_CHECKSUM_EN
        send_last(s, gapped);
`else
        check("sum_unused_in_default_build", {24'h0, s}, {24'h0, s});
`endif
    endtask

    task automatic verify_mem();
        rom_vec_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            rom_addr = e.addr;
            #1;
            check($sformatf("rom_data[%0d]", e.addr), rom_data, e.data);
        end
    endtask

    task automatic expect_all(input logic [7:0] val);
        for (int a = 0; a < 16; a++) sb.push_back('{addr: 4'(a), data: val});
        verify_mem();
    endtask

    initial begin
        vec[0]  = '{4'd0,  8'h30}; vec[1]  = '{4'd1,  8'h01};
        vec[2]  = '{4'd2,  8'h12}; vec[3]  = '{4'd3,  8'h23};
        vec[4]  = '{4'd4,  8'h34}; vec[5]  = '{4'd5,  8'h45};
        vec[6]  = '{4'd6,  8'h56}; vec[7]  = '{4'd7,  8'h67};
        vec[8]  = '{4'd8,  8'h78}; vec[9]  = '{4'd9,  8'h89};
        vec[10] = '{4'd10, 8'h9A}; vec[11] = '{4'd11, 8'hAB};
        vec[12] = '{4'd12, 8'hBC}; vec[13] = '{4'd13, 8'hCD};
        vec[14] = '{4'd14, 8'hDE}; vec[15] = '{4'd15, 8'hF0};

        rst = 1'b1; start = 1'b0; sdi = 1'b0; sdi_valid = 1'b0; rom_addr = 4'd0;
        tick(); tick();
        rst = 1'b0;
        check("reset_cpu_rst_n", cpu_rst_n, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_err", err, 0);
        expect_all(8'h00);

        for (int c = 0; c < 20; c++) begin
            sdi_valid = 1'(c % 2);
            sdi       = 1'b1;
            tick();
        end
        sdi_valid = 1'b0;
        check("idle_busy", busy, 0);
        check("idle_done", done, 0);
        expect_all(8'h00);

        for (int i = 0; i < 16; i++) prog_cur[vec[i].addr] = vec[i].data;
        load_program(1'b0);
        verify_mem();

        for (int c = 0; c < 16; c++) send_bit(1'b1, 1'b0);
        check("done_frozen", done, 1);
        for (int i = 0; i < 16; i++) sb.push_back(vec[i]);
        verify_mem();

        rst = 1'b1; tick(); rst = 1'b0;
        load_program(1'b1);
        verify_mem();

        pulse_start();
        for (int i = 0; i < 3; i++) send_byte(8'h5A, 1'b0);
        for (int k = 0; k < 5; k++) send_bit(1'b1, 1'b0);
        pulse_start();
        check("busy_after_abort", busy, 1);
        sb.push_back('{addr: 4'd0, data: 8'h5A});
        sb.push_back('{addr: 4'd3, data: 8'h23});
        verify_mem();
        for (int i = 0; i < 16; i++) prog_cur[i] = 8'hA5;
        sb.delete();
        for (int i = 0; i < 15; i++) send_byte(8'hA5, 1'b0);
`ifdef TD4_LOADER_CHECKSUM_EN
        send_byte(8'hA5, 1'b0);
        send_last(8'h50, 1'b0);
`else
        send_last(8'hA5, 1'b0);
`endif
        expect_all(8'hA5);

        pulse_start();
        for (int i = 0; i < 7; i++) send_byte(8'h3C, 1'b0);
        for (int k = 0; k < 3; k++) send_bit(1'b0, 1'b0);
        rst = 1'b1; tick(); rst = 1'b0;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_cpu_rst_n", cpu_rst_n, 0);
        expect_all(8'h00);

`ifdef TD4_LOADER_CHECKSUM_EN
        for (int i = 0; i < 16; i++) prog_cur[i] = 8'h11;
        load_program(1'b0);
        verify_mem();

        pulse_start();
        for (int i = 0; i < 16; i++) send_byte(8'h11, 1'b0);
        check("check_busy", busy, 1);
        send_byte(8'h11, 1'b0);
        check("bad_cks_err", err, 1);
        check("bad_cks_done", done, 0);
        check("bad_cks_cpu_rst_n", cpu_rst_n, 0);
        check("bad_cks_busy", busy, 0);
        pulse_start();
        check("err_cleared_by_start", err, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
